// File: rtl/memwb_pkg.sv
// rtl/memwb_pkg.sv - shared MEM/WB payload types and result-select codes
package memwb_pkg;

  localparam int MEMWB_DATA_WIDTH = 32;
  localparam int MEMWB_ADDR_WIDTH = 5;

  // Writeback mux select codes; 2'b11 is legal on the wire and simply selects 0
  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  typedef struct packed {
    logic [MEMWB_DATA_WIDTH-1:0] alu_result;
    logic [MEMWB_DATA_WIDTH-1:0] read_data;
    logic [MEMWB_DATA_WIDTH-1:0] pc_plus4;
    logic [MEMWB_ADDR_WIDTH-1:0] rd;
    logic                        reg_write;
    logic [1:0]                  result_src;
  } memwb_payload_t;

  localparam int MEMWB_PAYLOAD_WIDTH = $bits(memwb_payload_t);

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - generic two-slot valid/ready register with registered in_ready
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;
  logic             main_free;

  // in_ready depends only on state and rst so out_ready never reaches it combinationally
  assign in_ready  = ~rst & ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid_q | out_ready;

  // Next-state for both slots: flush, then skid drain, then direct load, then skid capture
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Slot registers; reset also clears payloads so outputs read zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/memwb_skid_reg.sv
// rtl/memwb_skid_reg.sv - MEM/WB boundary register with skid buffer; optional MEMWB_RETIRE_CNT_EN retire counter
module memwb_skid_reg
  import memwb_pkg::*;
#(
  parameter int DATA_WIDTH = MEMWB_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEMWB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_read_data,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_result_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_result,
  output logic [DATA_WIDTH-1:0] out_read_data,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_reg_write,
  output logic [1:0]            out_result_src
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retire_count
`endif
);

  // The payload struct fixes the field widths; DATA_WIDTH/ADDR_WIDTH must match the package
  memwb_payload_t in_payload;
  memwb_payload_t out_payload;
  logic           consume;

  // Pack MEM-stage fields into the stored payload; result_src is carried untouched
  always_comb begin
    in_payload            = '0;
    in_payload.alu_result = in_alu_result;
    in_payload.read_data  = in_read_data;
    in_payload.pc_plus4   = in_pc_plus4;
    in_payload.rd         = in_rd;
    in_payload.reg_write  = in_reg_write;
    in_payload.result_src = in_result_src;
  end

  skid_buffer #(
    .WIDTH(MEMWB_PAYLOAD_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign consume        = out_valid & out_ready;
  assign out_alu_result = out_payload.alu_result;
  assign out_read_data  = out_payload.read_data;
  assign out_pc_plus4   = out_payload.pc_plus4;
  assign out_rd         = out_payload.rd;
  assign out_result_src = out_payload.result_src;
  // A stale entry left behind by flush must never write the register file
  assign out_reg_write  = out_payload.reg_write & out_valid;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [31:0] retire_count_q, retire_count_d;

  // Count every consumed entry, including one consumed in a flush cycle; wraps naturally
  always_comb begin
    retire_count_d = retire_count_q;
    if (consume) retire_count_d = retire_count_q + 32'd1;
  end

  // Retire counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) retire_count_q <= '0;
    else     retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`else
  logic unused_consume;
  assign unused_consume = consume;
`endif

endmodule

// File: doc/memwb_skid_reg.md
# memwb_skid_reg

MEM/WB pipeline boundary register with valid/ready handshaking and a one-entry skid buffer, so a variable-latency memory stage and a stallable writeback port can be decoupled without a combinational ready path. It captures the ALU result, load data, PC+4 and the 2-bit result-select code from the MEM stage. It presents them, registered, to the writeback 3-way result multiplexer and the register-file write port.

## Interface
- DATA_WIDTH, 32, width of alu_result, read_data, pc_plus4
- ADDR_WIDTH, 5, register-file destination index width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all held and incoming entries this cycle
- in_valid  input  1  MEM stage presents a valid entry
- in_ready  output  1  block can accept an entry this cycle
- in_alu_result, in_read_data, in_pc_plus4  input  DATA_WIDTH each  payload words
- in_rd  input  ADDR_WIDTH  destination register
- in_reg_write  input  1  entry writes the register file
- in_result_src  input  2  result select: 00 ALU, 01 load data, 10 PC+4
- out_valid  output  1  output entry valid
- out_ready  input  1  writeback consumes the entry this cycle
- out_alu_result, out_read_data, out_pc_plus4  output  DATA_WIDTH each  to mux in0/in1/in2
- out_rd  output  ADDR_WIDTH
- out_reg_write  output  1  in_reg_write of the held entry AND out_valid
- out_result_src  output  2  drives mux sel
- retire_count  output  32  present only with MEMWB_RETIRE_CNT_EN

## Operation
- Two slots: main (drives outputs) and skid. Each slot has a valid bit.
- in_ready = ~rst & ~skid_valid, derived only from registers and rst, with no path from out_ready.
- Accept: in_valid & in_ready. Consume: out_valid & out_ready. out_valid = main_valid.
- Per cycle, evaluated in priority order:
  - rst: both valids 0, all payload registers 0.
  - flush: both valids 0. An accepted input in the same cycle is discarded. Payload registers may hold stale data.
  - Main empty or consumed, skid valid: main <- skid, skid empties. An accept in this cycle is impossible because in_ready = 0.
  - Main empty or consumed, skid empty, accept: main <- input.
  - Main held (valid & ~out_ready), accept: skid <- input, and in_ready drops next cycle.
  - Otherwise, hold.
- Payload fields pass through unmodified. in_result_src = 11 is carried unchanged (the mux yields 0 for it). It is not flagged.
- Entries never reorder, duplicate, or drop except on flush/rst.

## Timing
- Latency: an input accepted at edge N is visible on the outputs after edge N. Empty-pipe latency is 1 cycle.
- Throughput: 1 entry/cycle while out_ready = 1.
- After a single out_ready = 0 cycle with continuous input, the skid fills and in_ready = 0 for exactly one cycle after out_ready returns high.
- Reset values: out_valid 0, out_reg_write 0, out_result_src 00, all data outputs 0, retire_count 0. in_ready is 0 while rst = 1 and 1 on the first cycle after release.
- Reset asserted mid-stall drops both entries at the next edge.
- Flush and out_ready both high: the entry counts as consumed (retired) and the skid is still cleared.

## Configuration
- MEMWB_RETIRE_CNT_EN defined:
  - retire_count port exists and increments by 1 on every consume.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Cleared only by rst, not by flush.
- Undefined: port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package memwb_pkg:
  - localparams RESULT_SRC_ALU = 2'b00, RESULT_SRC_MEM = 2'b01, RESULT_SRC_PC4 = 2'b10.
  - Packed struct memwb_payload_t {alu_result, read_data, pc_plus4, rd, reg_write, result_src}.
- One generic sub-module skid_buffer, parameterised on payload width. It holds the main/skid slots and the handshake. memwb_skid_reg packs and unpacks the struct and owns the retire counter.

## Test plan
- Reset: hold rst 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, outputs 0. After release, in_ready = 1.
- Stream: 8 entries, alu_result = 0x10..0x17, out_ready = 1 -> the same values appear in order, each 1 cycle after acceptance, with no bubbles.
- Backpressure: out_ready = 0 for 1 cycle mid-stream -> skid holds the next entry, in_ready = 0 one cycle, and no loss or duplication.
- Flush: two entries held (out_ready = 0), flush = 1 with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and no later appearance of any of the three entries.
- Gating: entry with reg_write = 1, result_src = 10, pc_plus4 = 0x104 -> out_reg_write = 1 only while out_valid. out_result_src = 10.
- With MEMWB_RETIRE_CNT_EN: preload the counter via 5 consumes after a force to 32'hFFFF_FFFD -> reads 0x0000_0002.
